// File: rtl/mul_seq_ctrl.sv
// Sequencer for an external pipelined multiplier: accepts RV64 M-extension
// multiply ops from EX, stalls the front end, and returns the selected result.
module mul_seq_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ex_valid,
    input  logic [2:0]   ex_funct3,
    input  logic         ex_is_word,
    input  logic [63:0]  ex_rs1,
    input  logic [63:0]  ex_rs2,
    input  logic         flush,
    input  logic [129:0] mul_prod,
    output logic         mulstall,
    output logic         mul_start,
    output logic [64:0]  mul_a,
    output logic [64:0]  mul_b,
    output logic         res_valid,
    output logic [63:0]  res_data
);

    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_funct3;
    logic           op_word;

    logic           accept;
    logic           a_signed;
    logic           b_signed;
    logic [64:0]    ext_a;
    logic [64:0]    ext_b;
    logic [63:0]    sel_res;
    logic           unused_prod_bits;

    // The two top product bits never reach any result field.
    assign unused_prod_bits = ^mul_prod[129:128];

    always_comb begin
        accept   = (state == IDLE) && ex_valid && !ex_funct3[2] && !flush;
        a_signed = (ex_funct3[1:0] != 2'b11);
        b_signed = !ex_funct3[1];
        if (ex_is_word) begin
            ext_a = {{33{ex_rs1[31]}}, ex_rs1[31:0]};
            ext_b = {{33{ex_rs2[31]}}, ex_rs2[31:0]};
        end else begin
            ext_a = {a_signed & ex_rs1[63], ex_rs1};
            ext_b = {b_signed & ex_rs2[63], ex_rs2};
        end
    end

    always_comb begin
        if (op_word)
            sel_res = {{32{mul_prod[31]}}, mul_prod[31:0]};
        else if (op_funct3 == 2'b00)
            sel_res = mul_prod[63:0];
        else
            sel_res = mul_prod[127:64];
    end

    // Stall and strobe must react to flush within the same cycle.
    assign mulstall  = RST && (accept || ((state == BUSY) && !flush));
    assign res_valid = (state == DONE) && !flush;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            op_funct3 <= 2'b00;
            op_word   <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mul_start <= 1'b0;
                    cnt       <= '0;
                    if (accept) begin
                        state     <= BUSY;
                        op_funct3 <= ex_funct3[1:0];
                        op_word   <= ex_is_word;
                        mul_a     <= ext_a;
                        mul_b     <= ext_b;
                        mul_start <= 1'b1;
                    end
                end
                BUSY: begin
                    mul_start <= 1'b0;
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAT_C) begin
                        res_data <= sel_res;
                        state    <= DONE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    mul_start <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: begin
                    mul_start <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a 3-cycle behavioural multiplier
// and an arithmetic reference model of the M-extension multiply ops.
module tb_mul_seq_ctrl;

    localparam int LAT = 3;

    logic         CLK = 1'b0;
    logic         RST;
    logic         ex_valid;
    logic [2:0]   ex_funct3;
    logic         ex_is_word;
    logic [63:0]  ex_rs1;
    logic [63:0]  ex_rs2;
    logic         flush;
    logic [129:0] mul_prod;
    logic         mulstall;
    logic         mul_start;
    logic [64:0]  mul_a;
    logic [64:0]  mul_b;
    logic         res_valid;
    logic [63:0]  res_data;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    mul_seq_ctrl #(.MUL_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
        .ex_is_word(ex_is_word), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .flush(flush),
        .mul_prod(mul_prod), .mulstall(mulstall), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .res_valid(res_valid), .res_data(res_data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural multiplier: signed product delayed by LAT register stages.
    logic signed [129:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= $signed(mul_a) * $signed(mul_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_prod = pipe[LAT-1];

    function automatic logic [64:0] ref_ext(input logic [2:0] f3, input logic word,
                                            input logic [63:0] x, input bit is_b);
        bit sgn;
        if (word) return {{33{x[31]}}, x[31:0]};
        case (f3)
            3'd0, 3'd1: sgn = 1'b1;
            3'd2:       sgn = !is_b;
            default:    sgn = 1'b0;
        endcase
        return sgn ? {x[63], x} : {1'b0, x};
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic signed [31:0]  wa, wb;
        logic signed [63:0]  pw;
        logic signed [129:0] sa, sb, p;
        if (word) begin
            wa = a[31:0];
            wb = b[31:0];
            pw = wa * wb;
            return {{32{pw[31]}}, pw[31:0]};
        end
        sa = $signed(ref_ext(f3, 1'b0, a, 1'b0));
        sb = $signed(ref_ext(f3, 1'b0, b, 1'b1));
        p  = sa * sb;
        return (f3 == 3'd0) ? p[63:0] : p[127:64];
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [2:0] f3, input logic word,
                           input logic [63:0] a, input logic [63:0] b);
        ex_valid   = 1'b1;
        ex_funct3  = f3;
        ex_is_word = word;
        ex_rs1     = a;
        ex_rs2     = b;
    endtask

    // Drives one op from its IDLE cycle (cycle 1) to its DONE cycle (LAT+3),
    // holding ex_valid as a stalled pipeline would.
    task automatic run_op(input string name, input logic [2:0] f3, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input bit done_flush);
        logic [64:0] exp_a, exp_b;
        logic exp_stall, exp_start, exp_valid;
        exp_a = ref_ext(f3, word, a, 1'b0);
        exp_b = ref_ext(f3, word, b, 1'b1);
        present(f3, word, a, b);
        for (int n = 1; n <= LAT + 3; n++) begin
            if (n == LAT + 3 && done_flush) flush = 1'b1;
            @(negedge CLK);
            exp_stall = (n <= LAT + 2);
            exp_start = (n == 2);
            exp_valid = (n == LAT + 3) && !done_flush;
            checks++;
            if (mulstall !== exp_stall) begin
                fails++;
                $display("[TB] FAIL %s mulstall cycle %0d: got %b want %b", name, n, mulstall, exp_stall);
            end
            checks++;
            if (mul_start !== exp_start) begin
                fails++;
                $display("[TB] FAIL %s mul_start cycle %0d: got %b want %b", name, n, mul_start, exp_start);
            end
            checks++;
            if (res_valid !== exp_valid) begin
                fails++;
                $display("[TB] FAIL %s res_valid cycle %0d: got %b want %b", name, n, res_valid, exp_valid);
            end
            if (n == 2) begin
                checks++;
                if (mul_a !== exp_a || mul_b !== exp_b) begin
                    fails++;
                    $display("[TB] FAIL %s operands: got a=%h b=%h want a=%h b=%h", name, mul_a, mul_b, exp_a, exp_b);
                end
            end
            if (n == LAT + 3) last_done_cyc = cyc;
            next_cycle();
        end
        ex_valid = 1'b0;
        flush    = 1'b0;
        if (!done_flush) begin
            checks++;
            if (res_data !== exp_res) begin
                fails++;
                $display("[TB] FAIL %s res_data: got %h want %h", name, res_data, exp_res);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (mulstall !== 1'b0 || mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0 ||
            res_valid !== 1'b0 || res_data !== '0) begin
            fails++;
            $display("[TB] FAIL %s outputs: got stall=%b start=%b a=%h b=%h valid=%b data=%h want all zero",
                     name, mulstall, mul_start, mul_a, mul_b, res_valid, res_data);
        end
    endtask

    task automatic test_reset();
        RST   = 1'b0;
        flush = 1'b0;
        present(3'd0, 1'b0, 64'd5, 64'd6);
        #3;
        check_outputs_zero("reset_state");
        ex_valid = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        next_cycle();
    endtask

    task automatic test_directed();
        run_op("mul_7x-3", 3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1'b0);
        run_op("mulhu_max", 3'd3, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 1'b0);
        run_op("mulh_m1", 3'd1, 1'b0, '1, '1, 64'h0, 1'b0);
        run_op("mulhsu_m1x2", 3'd2, 1'b0, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("mulw", 3'd0, 1'b1, 64'h000000017FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    endtask

    task automatic test_hold();
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (res_data !== 64'hFFFFFFFFFFFFFFFE || res_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL hold: got data=%h valid=%b want data=fffffffffffffffe valid=0", res_data, res_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_busy();
        present(3'd0, 1'b0, 64'h1234, 64'h10);
        next_cycle();
        next_cycle();
        flush = 1'b1;
        @(negedge CLK);
        checks++;
        if (mulstall !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL flush_busy: got stall=%b valid=%b want 0 0", mulstall, res_valid);
        end
        next_cycle();
        flush = 1'b0;
        run_op("after_flush", 3'd0, 1'b0, 64'd21, 64'd2, 64'd42, 1'b0);
    endtask

    task automatic test_flush_done();
        run_op("flush_done", 3'd0, 1'b0, 64'd9, 64'd9, 64'd81, 1'b1);
    endtask

    task automatic test_back_to_back();
        int first_done;
        run_op("b2b_3x4", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 1'b0);
        first_done = last_done_cyc;
        run_op("b2b_5x6", 3'd0, 1'b0, 64'd5, 64'd6, 64'd30, 1'b0);
        checks++;
        if (last_done_cyc - first_done !== 6) begin
            fails++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles want 6", last_done_cyc - first_done);
        end
    endtask

    task automatic test_reset_busy();
        present(3'd0, 1'b0, 64'd100, 64'd100);
        next_cycle();
        next_cycle();
        #2;
        RST = 1'b0;
        #1;
        check_outputs_zero("reset_busy");
        ex_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        next_cycle();
        run_op("after_reset", 3'd0, 1'b0, 64'd11, 64'd13, 64'd143, 1'b0);
    endtask

    task automatic test_div();
        present(3'd4, 1'b0, 64'd50, 64'd7);
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if (mulstall !== 1'b0 || mul_start !== 1'b0 || res_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL div_ignored: got stall=%b start=%b valid=%b want 0 0 0", mulstall, mul_start, res_valid);
            end
            next_cycle();
        end
        ex_valid = 1'b0;
        run_op("after_div", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 1'b0);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 64'h8000000000000000;
            3: return {32'h0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  f3;
        logic        word;
        logic [63:0] a, b;
        for (int k = 0; k < 24; k++) begin
            f3   = 3'($urandom_range(0, 3));
            word = ($urandom_range(0, 3) == 0);
            a    = pick_operand();
            b    = pick_operand();
            run_op($sformatf("rand%0d", k), f3, word, a, b, ref_result(f3, word, a, b), 1'b0);
            if ($urandom_range(0, 1) == 1) next_cycle();
        end
    endtask

    initial begin
        ex_valid   = 1'b0;
        ex_funct3  = 3'd0;
        ex_is_word = 1'b0;
        ex_rs1     = '0;
        ex_rs2     = '0;
        flush      = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_flush_busy();
        test_flush_done();
        test_back_to_back();
        test_reset_busy();
        test_div();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 3: the fixed latency in cycles of the external pipelined multiplier, legal range 1-8.
REQ-002 The block SHALL have port CLK, input, 1: the single clock, rising edge.
REQ-003 The block SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port ex_valid, input, 1: an M-extension op is present in EX.
REQ-005 The block SHALL have port ex_funct3, input, 3: op select; funct3[2]=1 (divide) is not handled here.
REQ-006 The block SHALL have port ex_is_word, input, 1: MULW.
REQ-007 The block SHALL have ports ex_rs1 and ex_rs2, input, 64 each: the source operands.
REQ-008 The block SHALL have port flush, input, 1: branch/exception kill of the EX op.
REQ-009 The block SHALL have port mul_prod, input, 130: signed product of mul_a x mul_b, valid MUL_LAT cycles after mul_start.
REQ-010 The block SHALL have port mulstall, output, 1: holds IF/ID/EX.
REQ-011 The block SHALL have port mul_start, output, 1: one-cycle issue pulse to the multiplier.
REQ-012 The block SHALL have ports mul_a and mul_b, output, 65 each: the extended operands.
REQ-013 The block SHALL have port res_valid, output, 1: result strobe.
REQ-014 The block SHALL have port res_data, output, 64: the result.

Function
REQ-015 The block SHALL implement FSM states IDLE, BUSY and DONE, plus a counter cnt of width clog2(MUL_LAT+1).
REQ-016 An op SHALL be accepted when state is IDLE, ex_valid=1, ex_funct3[2]=0 and flush=0.
- Next state: BUSY, cnt=0.
- The block latches funct3 and is_word.
- mul_a, mul_b and mul_start=1 are registered and appear in the first BUSY cycle.
REQ-017 Operand extension SHALL be as follows:
- 000 MUL: both operands sign-extended.
- 001 MULH: both sign-extended.
- 010 MULHSU: rs1 sign-extended, rs2 zero-extended.
- 011 MULHU: both zero-extended.
- is_word: rs1[31:0] and rs2[31:0] sign-extended to 65 bits; funct3 is ignored.
REQ-018 mul_start SHALL be high only in the first BUSY cycle.
REQ-019 mul_a and mul_b SHALL hold their values through BUSY.
REQ-020 In BUSY, cnt SHALL increment each cycle.
- When cnt==MUL_LAT, the block captures the result from mul_prod and goes to DONE.
- MUL: res = prod[63:0].
- MULH, MULHSU, MULHU: res = prod[127:64].
- MULW: res = sign-extend(prod[31:0]).
REQ-021 DONE SHALL last exactly one cycle with res_valid=1 and mulstall=0, then return to IDLE unconditionally.
- It does not re-accept the still-present ex_valid.
REQ-022 mulstall SHALL be combinational: (IDLE and acceptance condition) or BUSY.
- Stall length per op is MUL_LAT+2 cycles.
REQ-023 flush=1 in BUSY SHALL force mulstall=0 in the same cycle and IDLE next cycle.
- No res_valid is produced; the in-flight mul_prod is ignored.
REQ-024 flush=1 in DONE SHALL suppress res_valid in that cycle.
REQ-025 ex_valid with funct3[2]=1 SHALL cause no stall and no state change.
REQ-026 Back-to-back ops SHALL be supported: the second op is accepted in the IDLE cycle immediately following DONE.
REQ-027 res_data SHALL hold its last value outside DONE.

Reset
REQ-028 RST=0 SHALL asynchronously force state IDLE, cnt=0, mul_start=0, mul_a=0, mul_b=0, res_valid=0 and res_data=0.
- mulstall=0 while in reset.
REQ-029 Reset asserted in BUSY SHALL abandon the op.
- After release, the block accepts a new op.
- Stale mul_prod values are never captured.

Verification
REQ-030 The bench SHALL use a behavioural multiplier with MUL_LAT=3 and cover the following scenarios:
- MUL, rs1=7, rs2=0xFFFFFFFFFFFFFFFD -> mulstall high 5 cycles, mul_start pulse in cycle 2, res_valid in cycle 6, res_data=0xFFFFFFFFFFFFFFEB.
- MULHU, rs1=rs2=0xFFFFFFFFFFFFFFFF -> res_data=0xFFFFFFFFFFFFFFFE.
- MULH -1 x -1 -> res_data=0.
- MULHSU rs1=-1, rs2=2 -> res_data=0xFFFFFFFFFFFFFFFF.
- MULW, rs1=0x000000017FFFFFFF, rs2=2 -> res_data=0xFFFFFFFFFFFFFFFE.
- Flush in the 2nd BUSY cycle -> mulstall=0 the same cycle, no res_valid, IDLE next cycle; a new MUL presented next cycle completes correctly.
- Two consecutive MULs (3x4, then 5x6) -> res_valid pulses 6 cycles apart with results 12 and 30; DONE never re-accepts the first op.
- RST low in BUSY -> all outputs 0 immediately.
- DIV op (funct3=100) with ex_valid=1 -> mulstall stays 0 and state remains IDLE.
